// File: rtl/score_keeper.sv
// Score keeper for the duck-hunt game: tracks score, round, ducks hit and shots left.
// Define SCORE_BONUS_EN to award PERFECT_BONUS for a fully hit round.
module score_keeper #(
   parameter logic [31:0] HIT_BASE        = 32'd500,
   parameter logic [31:0] HIT_STEP        = 32'd100,
   parameter logic [31:0] PERFECT_BONUS   = 32'd10000,
   parameter int          DUCKS_PER_ROUND = 10
) (
   input  logic        Clk,
   input  logic        Reset_n,
   input  logic [2:0]  state,
   input  logic        new_duck,
   input  logic        shot,
   input  logic        hit,
   output logic [31:0] score,
   output logic [3:0]  round,
   output logic [3:0]  ducks_hit,
   output logic [1:0]  shots_left,
   output logic        score_final
);

   localparam logic [2:0] G_START = 3'b000;
   localparam logic [2:0] G_PLAY  = 3'b001;
   localparam logic [2:0] G_RNDE  = 3'b010;
   localparam logic [2:0] G_DONE  = 3'b011;
   localparam logic [3:0] DPR     = 4'(DUCKS_PER_ROUND);

   typedef enum logic [1:0] {IDLE, PLAYING, TALLY, HOLD} fsm_t;

   fsm_t        fsm, fsm_nxt;
   logic [2:0]  state_q;
   logic [31:0] hit_val;
   logic        final_nxt;
   logic        chg;
   logic        hit_ok;

   function automatic logic [31:0] sat_add(input logic [31:0] a, input logic [31:0] b);
      logic [32:0] s;
      s = {1'b0, a} + {1'b0, b};
      return s[32] ? 32'hFFFF_FFFF : s[31:0];
   endfunction

   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         fsm         <= IDLE;
         state_q     <= G_START;
         score_final <= 1'b0;
      end else begin
         fsm         <= fsm_nxt;
         state_q     <= state;
         score_final <= final_nxt;
      end
   end

   // Once frozen in HOLD only a return to START is honoured.
   always_comb begin
      fsm_nxt   = fsm;
      final_nxt = 1'b0;
      chg       = (state_q != state);
      if (fsm == TALLY)
         fsm_nxt = PLAYING;
      if (chg && (fsm != HOLD || state == G_START)) begin
         case (state)
            G_START: fsm_nxt = IDLE;
            G_PLAY:  fsm_nxt = PLAYING;
            G_RNDE:  fsm_nxt = TALLY;
            G_DONE: begin
               fsm_nxt   = HOLD;
               final_nxt = 1'b1;
            end
            default: ;
         endcase
      end
   end

   // A hit lands if a shot is still available, or the hitting shot is this cycle's.
   assign hit_ok = hit && (shots_left != 2'd0 || shot) && (ducks_hit < DPR);

   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         score      <= '0;
         round      <= 4'd1;
         ducks_hit  <= '0;
         shots_left <= 2'd3;
         hit_val    <= HIT_BASE;
      end else begin
         case (fsm)
            IDLE: begin
               score      <= '0;
               round      <= 4'd1;
               ducks_hit  <= '0;
               shots_left <= 2'd3;
               hit_val    <= HIT_BASE;
            end
            PLAYING: begin
               if (hit_ok) begin
                  score     <= sat_add(score, hit_val);
                  ducks_hit <= ducks_hit + 4'd1;
               end
               if (new_duck)
                  shots_left <= 2'd3;
               else if (shot && shots_left != 2'd0)
                  shots_left <= shots_left - 2'd1;
            end
            TALLY: begin
`ifdef SCORE_BONUS_EN
               if (ducks_hit == DPR)
                  score <= sat_add(score, PERFECT_BONUS);
`endif
               round     <= (round == 4'd15) ? 4'd15 : round + 4'd1;
               hit_val   <= sat_add(hit_val, HIT_STEP);
               ducks_hit <= '0;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_score_keeper.sv
// Directed bench for score_keeper with a reference model feeding a scoreboard queue.
module tb_score_keeper;

   logic        Clk = 1'b0;
   logic        Reset_n = 1'b0;
   logic [2:0]  state = 3'b000;
   logic        new_duck = 1'b0, shot = 1'b0, hit = 1'b0;
   logic [31:0] score, s2_score;
   logic [3:0]  round, ducks_hit, s2_round, s2_ducks;
   logic [1:0]  shots_left, s2_shots;
   logic        score_final, s2_final;

   score_keeper dut (
      .Clk(Clk), .Reset_n(Reset_n), .state(state), .new_duck(new_duck), .shot(shot), .hit(hit),
      .score(score), .round(round), .ducks_hit(ducks_hit), .shots_left(shots_left),
      .score_final(score_final)
   );

   // Second instance with a huge per-hit value to reach score saturation quickly.
   score_keeper #(.HIT_BASE(32'hFFFF_FF00)) dut_sat (
      .Clk(Clk), .Reset_n(Reset_n), .state(state), .new_duck(new_duck), .shot(shot), .hit(hit),
      .score(s2_score), .round(s2_round), .ducks_hit(s2_ducks), .shots_left(s2_shots),
      .score_final(s2_final)
   );

   always #5 Clk = ~Clk;

   typedef struct {
      logic [31:0] score;
      logic [3:0]  round;
      logic [3:0]  ducks;
      logic [1:0]  shots;
   } exp_t;

   exp_t        sb[$];
   int          total = 0;
   int          bad = 0;
   string       phase = "reset";
   logic [31:0] m_score, m_val;
   int          m_round, m_ducks, m_shots;
   bit          m_act;

   function automatic logic [31:0] msat(input logic [31:0] a, input logic [31:0] b);
      logic [32:0] s;
      s = {1'b0, a} + {1'b0, b};
      return s[32] ? 32'hFFFF_FFFF : s[31:0];
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_score = 0; m_val = 500; m_round = 1; m_ducks = 0; m_shots = 3; m_act = 0;
   endtask

   task automatic push();
      exp_t e;
      e.score = m_score; e.round = 4'(m_round); e.ducks = 4'(m_ducks); e.shots = 2'(m_shots);
      sb.push_back(e);
   endtask

   task automatic pop_check();
      exp_t e;
      if (sb.size() == 0) begin
         chk({phase, ".queue_empty"}, 32'd1, 32'd0);
      end else begin
         e = sb.pop_front();
         chk({phase, ".score"}, score, e.score);
         chk({phase, ".round"}, 32'(round), 32'(e.round));
         chk({phase, ".ducks_hit"}, 32'(ducks_hit), 32'(e.ducks));
         chk({phase, ".shots_left"}, 32'(shots_left), 32'(e.shots));
      end
   endtask

   task automatic check_reset_vals(input string tag);
      chk({tag, ".score"}, score, 32'd0);
      chk({tag, ".round"}, 32'(round), 32'd1);
      chk({tag, ".ducks_hit"}, 32'(ducks_hit), 32'd0);
      chk({tag, ".shots_left"}, 32'(shots_left), 32'd3);
      chk({tag, ".score_final"}, 32'(score_final), 32'd0);
   endtask

   // One cycle of pulses: model updated and expectation queued, compared after the edge.
   task automatic cyc(input bit nd, input bit sh, input bit ht);
      new_duck = nd; shot = sh; hit = ht;
      if (m_act) begin
         if (ht && (m_shots > 0 || sh) && m_ducks < 10) begin
            m_score = msat(m_score, m_val);
            m_ducks++;
         end
         if (nd) m_shots = 3;
         else if (sh && m_shots > 0) m_shots--;
      end
      push();
      @(negedge Clk);
      new_duck = 0; shot = 0; hit = 0;
      pop_check();
   endtask

   // Game-state change; START and ROUND_END take effect one cycle after the FSM switches.
   task automatic go(input logic [2:0] s);
      state = s;
      case (s)
         3'b000: model_reset();
         3'b001: m_act = 1;
         3'b010: begin
`ifdef SCORE_BONUS_EN
            if (m_ducks == 10) m_score = msat(m_score, 32'd10000);
`endif
            m_round = (m_round == 15) ? 15 : m_round + 1;
            m_val   = m_val + 100;
            m_ducks = 0;
            m_act   = 0;
         end
         default: m_act = 0;
      endcase
      push();
      @(negedge Clk);
      @(negedge Clk);
      pop_check();
   endtask

   initial begin
      model_reset();
      repeat (2) @(negedge Clk);
      check_reset_vals("reset");
      Reset_n = 1'b1;

      phase = "three_hits";
      go(3'b001);
      cyc(1, 0, 0);
      cyc(0, 0, 1);
      chk("sat.first_hit", s2_score, 32'hFFFF_FF00);
      cyc(0, 0, 1);
      chk("sat.second_hit", s2_score, 32'hFFFF_FFFF);
      cyc(0, 0, 1);
      chk("three_hits.score", score, 32'd1500);
      chk("sat.held", s2_score, 32'hFFFF_FFFF);

      phase = "restart";
      go(3'b000);
      check_reset_vals("restart");

      phase = "out_of_shots";
      go(3'b001);
      cyc(1, 0, 0);
      repeat (4) cyc(0, 1, 0);
      cyc(0, 0, 1);
      chk("out_of_shots.shots", 32'(shots_left), 32'd0);
      chk("out_of_shots.score", score, 32'd0);

      phase = "last_shot_hit";
      cyc(1, 0, 0);
      cyc(0, 1, 0);
      cyc(0, 1, 0);
      cyc(0, 1, 1);
      chk("last_shot_hit.score", score, 32'd500);
      chk("last_shot_hit.shots", 32'(shots_left), 32'd0);

      phase = "full_round";
      go(3'b000);
      go(3'b001);
      cyc(1, 0, 0);
      repeat (11) cyc(0, 0, 1);
      chk("full_round.ducks_sat", 32'(ducks_hit), 32'd10);
      chk("full_round.score", score, 32'd5000);
      phase = "tally";
      go(3'b010);
`ifdef SCORE_BONUS_EN
      chk("tally.score", score, 32'd15000);
`else
      chk("tally.score", score, 32'd5000);
`endif
      chk("tally.round", 32'(round), 32'd2);
      phase = "round2";
      go(3'b001);
      cyc(0, 0, 1);
`ifdef SCORE_BONUS_EN
      chk("round2.score", score, 32'd15600);
`else
      chk("round2.score", score, 32'd5600);
`endif

      phase = "done";
      state = 3'b011;
      m_act = 0;
      @(negedge Clk);
      chk("done.final_pulse", 32'(score_final), 32'd1);
      @(negedge Clk);
      chk("done.final_clear", 32'(score_final), 32'd0);
      cyc(1, 1, 1);
      cyc(0, 0, 1);
      chk("done.final_low", 32'(score_final), 32'd0);

      phase = "async_reset";
      go(3'b000);
      go(3'b001);
      cyc(1, 0, 0);
      cyc(0, 0, 1);
      cyc(0, 1, 1);
      #2 Reset_n = 1'b0;
      #1 check_reset_vals("async_reset");
      #1 Reset_n = 1'b1;
      model_reset();
      m_act = 1;
      @(negedge Clk);
      phase = "play_after_reset";
      cyc(1, 0, 0);
      cyc(0, 0, 1);
      chk("play_after_reset.score", score, 32'd500);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
